reduction_arbiter: RTL and testbench

Shares one pipelined adder tree between NREQ requesters in the matrix multiply engine. Each requester offers a DIM-element product vector; the block grants one vector per cycle by round-robin and pushes it into a LAT-stage reduction pipeline. It returns the sum tagged with the requester index over a valid/ready output. The block replaces free-running, unsequenced summation with a flow-controlled, shared reduction resource.

---
 rtl/reduction_arbiter_pkg.sv | 9 +
 rtl/reduction_arbiter_pipelined_adder_tree.sv | 78 +++++++
 rtl/reduction_arbiter.sv | 87 ++++++++
 tb/tb_reduction_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_arbiter_pkg.sv
// Shared helpers for the reduction arbiter slice.
package reduction_arbiter_pkg;

  // Ceiling log2, used for LAT, RES_W and ID_W.
  function automatic int unsigned clog2(input int unsigned value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/reduction_arbiter_pipelined_adder_tree.sv
// LAT-stage pairwise reduction of a DIM-element vector with a global enable.
// Each level halves the element count and widens by one bit, so no overflow.
module pipelined_adder_tree
  import reduction_arbiter_pkg::*;
#(
  parameter int unsigned DIM   = 8,
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 2,
  localparam int unsigned LAT   = clog2(DIM),
  localparam int unsigned RES_W = W + LAT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [DIM*W-1:0] vector,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [RES_W-1:0] sum,
  output logic [LAT-1:0]   stage_valid
);

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int unsigned N  = DIM >> (k + 1);
    localparam int unsigned LW = W + k + 1;

    logic [N*LW-1:0]  data_d;
    logic [N*LW-1:0]  data_q;
    logic             src_valid;
    logic [TAG_W-1:0] src_tag;
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_first
      assign src_valid = in_valid;
      assign src_tag   = in_tag;
      // Pairwise sums of the raw input elements.
      always_comb begin
        data_d = '0;
        for (int i = 0; i < int'(N); i++) begin
          data_d[i*LW +: LW] = LW'(vector[(2*i)*W +: W]) + LW'(vector[(2*i+1)*W +: W]);
        end
      end
    end else begin : g_next
      assign src_valid = g_lvl[k-1].valid_q;
      assign src_tag   = g_lvl[k-1].tag_q;
      // Pairwise sums of the previous level's partial sums.
      always_comb begin
        data_d = '0;
        for (int i = 0; i < int'(N); i++) begin
          data_d[i*LW +: LW] = LW'(g_lvl[k-1].data_q[(2*i)*(LW-1) +: (LW-1)])
                             + LW'(g_lvl[k-1].data_q[(2*i+1)*(LW-1) +: (LW-1)]);
        end
      end
    end

    // Stage register: shifts only on the global enable, freezes otherwise.
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        data_q  <= '0;
      end else if (en) begin
        valid_q <= src_valid;
        tag_q   <= src_tag;
        data_q  <= data_d;
      end
    end

    assign stage_valid[k] = valid_q;
  end

  assign out_valid = g_lvl[LAT-1].valid_q;
  assign out_tag   = g_lvl[LAT-1].tag_q;
  assign sum       = g_lvl[LAT-1].data_q;

endmodule

// File: rtl/reduction_arbiter.sv
// Round-robin sharing of one pipelined adder tree among NREQ requesters.
// Results return tagged with the requester index over valid/ready.
module reduction_arbiter
  import reduction_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DIM  = 8,
  parameter int unsigned W    = 64,
  localparam int unsigned LAT   = clog2(DIM),
  localparam int unsigned RES_W = W + LAT,
  localparam int unsigned ID_W  = clog2(NREQ)
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DIM*W-1:0] req_vector,
  output logic [NREQ-1:0]       req_ready,
  output logic                  sum_valid,
  output logic [RES_W-1:0]      sum,
  output logic [ID_W-1:0]       sum_id,
  input  logic                  sum_ready,
  output logic                  busy
);

  logic            en;
  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic            transfer;
  logic [ID_W-1:0] last_grant_q;
  logic [DIM*W-1:0] grant_vector;
  logic [LAT-1:0]  stage_valid;

  assign en = !sum_valid || sum_ready;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned idx;
      idx = (int'(last_grant_q) + i) % NREQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign transfer = found && en;

  // Winner sees ready only when the pipeline can advance.
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  assign grant_vector = req_vector[int'(grant_idx)*DIM*W +: DIM*W];

  // Remember the last winner; held across idle and stalled cycles.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant_q <= ID_W'(NREQ - 1);
    end else if (transfer) begin
      last_grant_q <= grant_idx;
    end
  end

  pipelined_adder_tree #(
    .DIM   (DIM),
    .W     (W),
    .TAG_W (ID_W)
  ) u_tree (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .en          (en),
    .in_valid    (transfer),
    .in_tag      (grant_idx),
    .vector      (grant_vector),
    .out_valid   (sum_valid),
    .out_tag     (sum_id),
    .sum         (sum),
    .stage_valid (stage_valid)
  );

  assign busy = |stage_valid;

endmodule

// File: tb/tb_reduction_arbiter.sv
// Directed self-checking bench for reduction_arbiter (NREQ=4, DIM=8, W=8).
module tb_reduction_arbiter;

  localparam int NREQ = 4;
  localparam int DIM  = 8;
  localparam int W    = 8;

  logic                  Clock;
  logic                  Reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DIM*W-1:0] req_vector;
  logic [NREQ-1:0]       req_ready;
  logic                  sum_valid;
  logic [10:0]           sum;
  logic [1:0]            sum_id;
  logic                  sum_ready;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  reduction_arbiter #(
    .NREQ (NREQ),
    .DIM  (DIM),
    .W    (W)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_vector (req_vector),
    .req_ready  (req_ready),
    .sum_valid  (sum_valid),
    .sum        (sum),
    .sum_id     (sum_id),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Requester r gets elements base, base+1, ..., base+7.
  task automatic set_ramp(input int r, input int base);
    for (int e = 0; e < DIM; e++) req_vector[(r*DIM+e)*W +: W] = W'(base + e);
  endtask

  task automatic do_reset();
    Reset_n   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    Reset_n = 1'b1;
    settle();
  endtask

  task automatic check_out(input string tag, input logic v, input logic [10:0] s,
                           input logic [1:0] id);
    check({tag, ".valid"}, 32'(sum_valid), 32'(v));
    if (v) begin
      check({tag, ".sum"}, 32'(sum), 32'(s));
      check({tag, ".id"}, 32'(sum_id), 32'(id));
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    req_valid  = '0;
    req_vector = '0;
    sum_ready  = 1'b1;
    do_reset();

    // Reset state
    check("rst.sum_valid", 32'(sum_valid), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.sum_id", 32'(sum_id), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd0);

    // 1: single requester 2, all 0xFF -> 0x7F8
    for (int e = 0; e < DIM; e++) req_vector[(2*DIM+e)*W +: W] = 8'hFF;
    req_valid = 4'b0100;
    settle();
    check("t1.ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    settle();
    check("t1.busy", 32'(busy), 32'd1);
    check_out("t1.e0", 1'b0, '0, '0);
    tick();
    check_out("t1.e1", 1'b0, '0, '0);
    tick();
    check_out("t1.e2", 1'b1, 11'h7F8, 2'd2);
    tick();
    check_out("t1.e3", 1'b0, '0, '0);
    check("t1.idle", 32'(busy), 32'd0);

    // 2: all four continuously valid -> 0,1,2,3,0 streaming back-to-back
    do_reset();
    set_ramp(0, 1);   // 36
    set_ramp(1, 17);  // 164
    set_ramp(2, 33);  // 292
    set_ramp(3, 49);  // 420
    for (int c = 0; c < 8; c++) begin
      logic [10:0] exp_sum [4];
      exp_sum[0] = 11'd36;
      exp_sum[1] = 11'd164;
      exp_sum[2] = 11'd292;
      exp_sum[3] = 11'd420;
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      settle();
      if (c < 5) check($sformatf("t2.ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 3) check_out($sformatf("t2.res%0d", c - 3), 1'b1, exp_sum[(c-3)%4], 2'((c-3)%4));
      tick();
    end
    check_out("t2.drain", 1'b0, '0, '0);

    // 3: fill pipeline, stall 5 cycles, release
    do_reset();
    sum_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("t3.fill%0d", c), 32'(req_ready), 32'(1 << c));
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("t3.stall_ready%0d", c), 32'(req_ready), 32'd0);
      check($sformatf("t3.stall_busy%0d", c), 32'(busy), 32'd1);
      check_out($sformatf("t3.stall%0d", c), 1'b1, 11'd36, 2'd0);
      tick();
    end
    req_valid = '0;
    sum_ready = 1'b1;
    settle();
    check_out("t3.q0", 1'b1, 11'd36, 2'd0);
    tick();
    check_out("t3.q1", 1'b1, 11'd164, 2'd1);
    tick();
    check_out("t3.q2", 1'b1, 11'd292, 2'd2);
    tick();
    check_out("t3.q3", 1'b0, '0, '0);
    check("t3.idle", 32'(busy), 32'd0);

    // 4: steer last_grant to 1, then 4'b1010 alternates 3,1,3
    do_reset();
    req_valid = 4'b0001;
    settle();
    check("t4.pre0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    settle();
    check("t4.pre1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1010;
    settle();
    check("t4.g3a", 32'(req_ready), 32'b1000);
    tick();
    check("t4.g1", 32'(req_ready), 32'b0010);
    tick();
    check("t4.g3b", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;

    // 6: requester 1 with {1..8} -> 36, id 1
    do_reset();
    set_ramp(1, 1);
    req_valid = 4'b0010;
    settle();
    check("t6.ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_out("t6.res", 1'b1, 11'd36, 2'd1);
    tick();

    // 5: asynchronous reset mid-cycle with 3 results in flight
    do_reset();
    req_valid = 4'b1111;
    tick();
    tick();
    tick();
    req_valid = '0;
    settle();
    check_out("t5.pre", 1'b1, 11'd36, 2'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t5.async_valid", 32'(sum_valid), 32'd0);
    check("t5.async_sum", 32'(sum), 32'd0);
    check("t5.async_id", 32'(sum_id), 32'd0);
    check("t5.async_busy", 32'(busy), 32'd0);
    tick();
    Reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("t5.stale%0d", c), 32'(sum_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1111;
    settle();
    check("t5.first", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
